// File: rtl/addr_decoder_cfg_loader.sv
// Framed host byte stream -> auto-incrementing byte writes into the address-decoder config store.
// Frame: SYNC, ADDR, LEN, LEN data bytes, CSUM with (ADDR+LEN+sum(data)+CSUM) mod 256 == 0.
module addr_decoder_cfg_loader #(
    parameter int          TIMEOUT_CYC = 1024,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
    input  logic       cfg_clk,
    input  logic       cfg_rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       cfg_we,
    output logic [7:0] cfg_addr,
    output logic [7:0] cfg_wdata,
    output logic       frame_done,
    output logic       frame_ok,
    output logic       csum_err,
    output logic       tout_err,
    input  logic       err_clr
);

    localparam int             CW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0]  TOUT_MAX = CW'(TIMEOUT_CYC);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LEN,
        S_DATA,
        S_CSUM
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    ptr_q, ptr_d;
    logic [7:0]    rem_q, rem_d;
    logic [7:0]    sum_q, sum_d;
    logic [CW-1:0] tcnt_q, tcnt_d;
    logic          we_q, we_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          done_q, done_d;
    logic          ok_q, ok_d;
    logic          cerr_q, cerr_d;
    logic          terr_q, terr_d;

    logic          accept;
    logic [7:0]    csum_chk;
    logic          csum_set;
    logic          tout_set;

    // The block never back-pressures; it is only unready while held in reset.
    assign in_ready = ~cfg_rst;
    assign accept   = in_valid & in_ready;
    assign csum_chk = sum_q + in_data;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave a latch behind.
        state_d  = state_q;
        ptr_d    = ptr_q;
        rem_d    = rem_q;
        sum_d    = sum_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = 1'b0;
        done_d   = 1'b0;
        ok_d     = 1'b0;
        csum_set = 1'b0;
        tout_set = 1'b0;
        tcnt_d   = (state_q == S_IDLE || accept) ? '0 : tcnt_q + CW'(1);

        case (state_q)
            S_IDLE: begin
                if (accept && in_data == SYNC_BYTE) state_d = S_ADDR;
            end
            S_ADDR: begin
                if (accept) begin
                    ptr_d   = in_data;
                    sum_d   = in_data;
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (accept) begin
                    rem_d   = in_data;
                    sum_d   = csum_chk;
                    state_d = (in_data != 8'd0) ? S_DATA : S_CSUM;
                end
            end
            S_DATA: begin
                if (accept) begin
                    we_d    = 1'b1;
                    addr_d  = ptr_q;
                    wdata_d = in_data;
                    ptr_d   = ptr_q + 8'd1;
                    rem_d   = rem_q - 8'd1;
                    sum_d   = csum_chk;
                    if (rem_q == 8'd1) state_d = S_CSUM;
                end
            end
            S_CSUM: begin
                if (accept) begin
                    done_d   = 1'b1;
                    ok_d     = (csum_chk == 8'd0);
                    csum_set = (csum_chk != 8'd0);
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort only when the limit is reached with no byte arriving in that same cycle.
        if (state_q != S_IDLE && !accept && tcnt_q == TOUT_MAX) begin
            state_d  = S_IDLE;
            done_d   = 1'b1;
            ok_d     = 1'b0;
            tout_set = 1'b1;
            tcnt_d   = '0;
        end

        cerr_d = csum_set | (cerr_q & ~err_clr);
        terr_d = tout_set | (terr_q & ~err_clr);
    end

    always_ff @(posedge cfg_clk) begin
        if (cfg_rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
            sum_q   <= '0;
            tcnt_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            cerr_q  <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples the pre-edge value of the others.
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            sum_q   <= sum_d;
            tcnt_q  <= tcnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            ok_q    <= ok_d;
            cerr_q  <= cerr_d;
            terr_q  <= terr_d;
        end
    end

    assign cfg_we     = we_q;
    assign cfg_addr   = addr_q;
    assign cfg_wdata  = wdata_q;
    assign frame_done = done_q;
    assign frame_ok   = ok_q;
    assign csum_err   = cerr_q;
    assign tout_err   = terr_q;

endmodule
